rle_stream_expander: RTL and testbench
======================================

# rle_stream_expander

Parametrised single-clock successor to the serial RLE decompressor. It accepts an encoded serial bit stream under a valid/ready handshake and buffers completed tokens in a DEPTH-entry token FIFO. It expands each token into SYM_W-bit symbols on a parallel output with backpressure. Tokens are either run tokens (symbol repeated count+1 times) or literal tokens (symbol emitted once). It sits between the compressed-stream source and the symbol consumer.

## Interface
- SYM_W, 1: symbol width in bits.
- COUNT_W, 2: run-count field width; run length = count+1, range 1..2^COUNT_W.
- DEPTH, 4: token FIFO entries; power of two, ≥2.
- sclk  input  1  sole clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- serIn  input  1  encoded stream bit.
- serInValid  input  1  serIn is valid this cycle.
- stackFull  output  1  FIFO full; serial ready is ~stackFull.
- symOut  output  SYM_W  current expanded symbol.
- outValid  output  1  symOut valid.
- outReady  input  1  consumer accepts symOut.
- busy  output  1  partial token, FIFO non-empty, or emission in progress.

## Operation
- A bit is accepted on a rising edge when serInValid && ~stackFull. No other bits are consumed.
- Token format, first bit first:
  - Flag bit: 1 = run, 0 = literal.
  - Symbol, SYM_W bits, MSB first.
  - Run tokens only: count, COUNT_W bits, MSB first.
- Token length is 1+SYM_W bits for a literal and 1+SYM_W+COUNT_W bits for a run.
- Deserializer FSM states:
  - D_FLAG: captures the flag, then goes to D_SYM.
  - D_SYM: shifts the symbol in. After SYM_W bits it goes to D_CNT if run, else pushes the token and returns to D_FLAG.
  - D_CNT: shifts the count in. After COUNT_W bits it pushes the token and returns to D_FLAG.
  - A bit counter of width ceil(log2(max(SYM_W,COUNT_W)+1)) tracks position. The FSM only advances on accepted bits.
- FIFO entry: {symbol, count}. A literal is stored with count = 0, so literal and run-of-1 behave identically downstream.
- Push: on the same edge that accepts the token's last bit.
- Emitter FSM states:
  - E_IDLE: if the FIFO is non-empty, pop the head into symbol/remaining registers and go to E_EMIT.
  - E_EMIT: outValid = 1 and symOut = held symbol.
  - On each outValid && outReady with remaining > 0: decrement remaining.
  - On outValid && outReady with remaining == 0 (last symbol): pop the next token on the same edge if the FIFO is non-empty and stay in E_EMIT; otherwise go to E_IDLE.
- The remaining counter is COUNT_W bits wide and never wraps: it decrements only while > 0.
- FIFO occupancy counter is log2(DEPTH)+1 bits. Simultaneous push and pop leaves the count unchanged. A push while full is impossible because ready is low.
- stackFull = (count == DEPTH).
- busy = (deserializer not in D_FLAG) | (FIFO count ≠ 0) | (emitter in E_EMIT).
- symOut is held stable while outValid && ~outReady.

## Timing
- On reset assertion, immediately:
  - stackFull=0, outValid=0, symOut=0, busy=0.
  - FSMs go to D_FLAG/E_IDLE; FIFO pointers and count are 0.
  - Any partial token is discarded.
- Reset mid-operation is identical to power-up reset: the in-flight token, all buffered tokens and any partial run are lost.
- Latency: when the last bit is accepted at edge k and the emitter is idle, the pop occurs at edge k+1 and outValid is high after edge k+1.
- Throughput: one symbol per cycle with outReady=1, with no bubble between consecutive tokens while the FIFO is non-empty.
- A run token with count c produces exactly c+1 handshakes. A literal produces exactly 1.
- stackFull rises after the push edge that fills the FIFO. It falls after the next pop edge.
- The serial source may stall (serInValid=0) at any bit position; deserializer state is held.

## Test plan
- SYM_W=4, COUNT_W=3, DEPTH=2 for all cases.
- Reset: assert rst mid-stream -> immediately outValid=0, stackFull=0, busy=0, symOut=0. After release, the next fresh token decodes correctly and the partial token is discarded.
- Run token 1,1010,011 -> symOut=0xA with outValid for exactly 4 handshakes. outValid first high one cycle after the last-bit edge. busy=0 afterward.
- Literal token 0,0101 followed by run 1,0011,000 -> outputs 0x5 then 0x3, back to back with no bubble when outReady=1.
- Count extremes: run with count 7 -> 8 symbols; run with count 0 -> 1 symbol. No wrap of the remaining counter.
- Backpressure: outReady=0 and 3 run tokens sent -> 1 token in the emitter and 2 in the FIFO, then stackFull=1 and serial input stalls with no bits lost. Release outReady -> all symbols are emitted in order with symOut stable during stalls.
- Random serInValid and outReady toggling over 200 tokens -> output symbol sequence matches the reference expansion exactly.

Source files
------------

// File: rtl/rle_stream_expander.sv
// ----------------------------------------------------------------------------
// rle_stream_expander
//
// Purpose:
//   Decodes a serial run-length encoded bit stream into a parallel stream of
//   SYM_W-bit symbols. Serial tokens are deserialized and then queued in a
//   DEPTH-entry token FIFO. An emitter expands each queued token into one or
//   more symbols and honours backpressure from the consumer.
//
//   Token format, first bit first:
//     flag (1 = run, 0 = literal), symbol (SYM_W bits, MSB first),
//     count (COUNT_W bits, MSB first, run tokens only).
//   A run emits its symbol count+1 times. A literal emits its symbol once.
//
// Parameters:
//   SYM_W    symbol width in bits
//   COUNT_W  run-count field width (run length 1 .. 2**COUNT_W)
//   DEPTH    token FIFO entries, power of two, >= 2
//
// Ports:
//   sclk        in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   serIn       in   encoded stream bit
//   serInValid  in   serIn is valid this cycle
//   stackFull   out  token FIFO full; the serial side is ready when this is low
//   symOut      out  current expanded symbol
//   outValid    out  symOut is valid
//   outReady    in   consumer accepts symOut
//   busy        out  partial token, queued tokens or emission in progress
// ----------------------------------------------------------------------------
module rle_stream_expander #(
    parameter int SYM_W   = 1,
    parameter int COUNT_W = 2,
    parameter int DEPTH   = 4
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             serIn,
    input  logic             serInValid,
    output logic             stackFull,
    output logic [SYM_W-1:0] symOut,
    output logic             outValid,
    input  logic             outReady,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int MAX_FIELD = (SYM_W > COUNT_W) ? SYM_W : COUNT_W;
    localparam int BC_W      = $clog2(MAX_FIELD + 1);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int OCC_W     = PTR_W + 1;
    localparam int TOK_W     = SYM_W + COUNT_W;

    // Deserializer states
    localparam logic [1:0] D_FLAG = 2'd0;
    localparam logic [1:0] D_SYM  = 2'd1;
    localparam logic [1:0] D_CNT  = 2'd2;

    // Emitter states
    localparam logic [0:0] E_IDLE = 1'b0;
    localparam logic [0:0] E_EMIT = 1'b1;

    // ------------------------------------------------------------------------
    // Deserializer registers
    // ------------------------------------------------------------------------
    logic [1:0]         d_state_q, d_state_d;
    logic               d_flag_q,  d_flag_d;
    logic [SYM_W-1:0]   d_sym_q,   d_sym_d;
    logic [COUNT_W-1:0] d_cnt_q,   d_cnt_d;
    logic [BC_W-1:0]    d_bit_q,   d_bit_d;

    // ------------------------------------------------------------------------
    // FIFO registers
    // ------------------------------------------------------------------------
    logic [TOK_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [OCC_W-1:0]   occ_q,     occ_d;

    // ------------------------------------------------------------------------
    // Emitter registers
    // ------------------------------------------------------------------------
    logic [0:0]         e_state_q, e_state_d;
    logic [SYM_W-1:0]   e_sym_q,   e_sym_d;
    logic [COUNT_W-1:0] e_rem_q,   e_rem_d;

    // ------------------------------------------------------------------------
    // Handshake and datapath nets
    // ------------------------------------------------------------------------
    logic               bit_acc;
    logic               push;
    logic [SYM_W-1:0]   push_sym;
    logic [COUNT_W-1:0] push_cnt;
    logic               pop;
    logic               fifo_empty;
    logic [TOK_W-1:0]   head_tok;
    logic [SYM_W-1:0]   head_sym;
    logic [COUNT_W-1:0] head_cnt;
    logic               out_fire;
    logic               last_sym;
    logic [SYM_W-1:0]   sym_shift;
    logic [COUNT_W-1:0] cnt_shift;

    // A bit is consumed only when the source offers it and there is room for
    // the token it may complete.
    assign bit_acc = serInValid & ~stackFull;

    // Shift-left-with-new-LSB for the symbol and count fields. Single-bit
    // fields are simply replaced by the incoming bit.
    if (SYM_W == 1) begin : g_sym_shift_1
        assign sym_shift = serIn;
    end else begin : g_sym_shift_n
        assign sym_shift = {d_sym_q[SYM_W-2:0], serIn};
    end

    if (COUNT_W == 1) begin : g_cnt_shift_1
        assign cnt_shift = serIn;
    end else begin : g_cnt_shift_n
        assign cnt_shift = {d_cnt_q[COUNT_W-2:0], serIn};
    end

    // ------------------------------------------------------------------------
    // Deserializer next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        d_state_d = d_state_q;
        d_flag_d  = d_flag_q;
        d_sym_d   = d_sym_q;
        d_cnt_d   = d_cnt_q;
        d_bit_d   = d_bit_q;
        push      = 1'b0;
        push_sym  = d_sym_q;
        push_cnt  = '0;

        case (d_state_q)
            D_FLAG: begin
                if (bit_acc) begin
                    d_flag_d  = serIn;
                    d_bit_d   = '0;
                    d_state_d = D_SYM;
                end
            end

            D_SYM: begin
                if (bit_acc) begin
                    d_sym_d = sym_shift;
                    if (d_bit_q == BC_W'(SYM_W - 1)) begin
                        d_bit_d = '0;
                        if (d_flag_q) begin
                            d_cnt_d   = '0;
                            d_state_d = D_CNT;
                        end else begin
                            // Literal: stored as a run of one so the
                            // emitter treats both token kinds alike.
                            push      = 1'b1;
                            push_sym  = sym_shift;
                            push_cnt  = '0;
                            d_state_d = D_FLAG;
                        end
                    end else begin
                        d_bit_d = d_bit_q + 1'b1;
                    end
                end
            end

            D_CNT: begin
                if (bit_acc) begin
                    d_cnt_d = cnt_shift;
                    if (d_bit_q == BC_W'(COUNT_W - 1)) begin
                        push      = 1'b1;
                        push_sym  = d_sym_q;
                        push_cnt  = cnt_shift;
                        d_bit_d   = '0;
                        d_state_d = D_FLAG;
                    end else begin
                        d_bit_d = d_bit_q + 1'b1;
                    end
                end
            end

            default: begin
                d_state_d = D_FLAG;
                d_bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            d_state_q <= D_FLAG;
            d_flag_q  <= 1'b0;
            d_sym_q   <= '0;
            d_cnt_q   <= '0;
            d_bit_q   <= '0;
        end else begin
            d_state_q <= d_state_d;
            d_flag_q  <= d_flag_d;
            d_sym_q   <= d_sym_d;
            d_cnt_q   <= d_cnt_d;
            d_bit_q   <= d_bit_d;
        end
    end

    // ------------------------------------------------------------------------
    // Token FIFO
    // ------------------------------------------------------------------------
    assign fifo_empty = (occ_q == '0);
    assign stackFull  = (occ_q == OCC_W'(DEPTH));

    // Storage carries no reset; validity is tracked by the occupancy count.
    always_ff @(posedge sclk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {push_sym, push_cnt};
        end
    end

    // Head entry feeds the emitter registers, which act as the read stage.
    assign head_tok = fifo_mem[rd_ptr_q];
    assign head_sym = head_tok[TOK_W-1:COUNT_W];
    assign head_cnt = head_tok[COUNT_W-1:0];

    always_comb begin
        // Pointers wrap naturally because DEPTH is a power of two.
        wr_ptr_d = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;
        occ_d    = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // ------------------------------------------------------------------------
    // Emitter
    // ------------------------------------------------------------------------
    assign outValid = (e_state_q == E_EMIT);
    assign symOut   = e_sym_q;
    assign out_fire = outValid & outReady;
    assign last_sym = (e_rem_q == '0);

    // Pop when idle, or on the final handshake of the current token so the
    // next token follows without a bubble.
    assign pop = ~fifo_empty & ((e_state_q == E_IDLE) | (out_fire & last_sym));

    always_comb begin
        e_state_d = e_state_q;
        e_sym_d   = e_sym_q;
        e_rem_d   = e_rem_q;

        case (e_state_q)
            E_IDLE: begin
                if (pop) begin
                    e_sym_d   = head_sym;
                    e_rem_d   = head_cnt;
                    e_state_d = E_EMIT;
                end
            end

            E_EMIT: begin
                if (out_fire) begin
                    if (!last_sym) begin
                        // Only decrements while non-zero, so it never wraps.
                        e_rem_d = e_rem_q - 1'b1;
                    end else if (pop) begin
                        e_sym_d = head_sym;
                        e_rem_d = head_cnt;
                    end else begin
                        e_state_d = E_IDLE;
                    end
                end
            end

            default: begin
                e_state_d = E_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            e_state_q <= E_IDLE;
            e_sym_q   <= '0;
            e_rem_q   <= '0;
        end else begin
            e_state_q <= e_state_d;
            e_sym_q   <= e_sym_d;
            e_rem_q   <= e_rem_d;
        end
    end

    // ------------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------------
    assign busy = (d_state_q != D_FLAG) | ~fifo_empty | outValid;

endmodule

// File: tb/tb_rle_stream_expander.sv
module tb_rle_stream_expander;

    localparam int SYM_W   = 4;
    localparam int COUNT_W = 3;
    localparam int DEPTH   = 2;

    logic             sclk = 1'b0;
    logic             rst;
    logic             serIn;
    logic             serInValid;
    logic             stackFull;
    logic [SYM_W-1:0] symOut;
    logic             outValid;
    logic             outReady;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] got_q[$];
    time        got_t[$];
    logic [3:0] exp_q[$];
    int         acc_bits = 0;

    int   rdy_mode = 0;     // 0: drive rdy_val, 1: random
    logic rdy_val  = 1'b1;
    logic prev_stall = 1'b0;
    logic [3:0] prev_sym = 4'h0;
    logic sender_done;

    typedef struct {
        logic       flag;
        logic [3:0] sym;
        logic [2:0] cnt;
        int         exp_n;
    } vec_t;

    vec_t vecs[6];

    rle_stream_expander #(
        .SYM_W  (SYM_W),
        .COUNT_W(COUNT_W),
        .DEPTH  (DEPTH)
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .serIn     (serIn),
        .serInValid(serInValid),
        .stackFull (stackFull),
        .symOut    (symOut),
        .outValid  (outValid),
        .outReady  (outReady),
        .busy      (busy)
    );

    initial forever #5 sclk = ~sclk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Consumer ready driver
    initial begin
        outReady = 1'b1;
        forever begin
            @(posedge sclk);
            #1;
            outReady = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Output monitor: records handshakes and checks hold during stalls
    initial begin
        forever begin
            @(negedge sclk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_hold", 32'(outValid), 32'd1);
                    check("stall_sym_hold", 32'(symOut), 32'(prev_sym));
                end
                if (outValid && outReady) begin
                    got_q.push_back(symOut);
                    got_t.push_back($time);
                end
                if (serInValid && !stackFull) acc_bits++;
                prev_stall = outValid && !outReady;
                prev_sym   = symOut;
            end
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        logic ok;
        if (gap > 0) begin
            serInValid = 1'b0;
            repeat (gap) tick();
        end
        serIn      = b;
        serInValid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sclk);
            ok = !stackFull;
            tick();
            if (ok) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL serial_accept_timeout: actual=stalled required=accepted");
    endtask

    task automatic send_token(input logic flag, input logic [3:0] sym,
                              input logic [2:0] cnt, input int maxgap);
        send_bit(flag, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        for (int i = 3; i >= 0; i--)
            send_bit(sym[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        if (flag) begin
            for (int i = 2; i >= 0; i--)
                send_bit(cnt[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic push_exp(input logic flag, input logic [3:0] sym, input logic [2:0] cnt);
        int n;
        n = flag ? (int'(cnt) + 1) : 1;
        repeat (n) exp_q.push_back(sym);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) return;
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL idle_timeout: actual=busy required=idle");
    endtask

    task automatic compare_queues(input string name);
        int n;
        check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_sym%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        check({name, "_outValid"},  32'(outValid),  32'd0);
        check({name, "_stackFull"}, 32'(stackFull), 32'd0);
        check({name, "_busy"},      32'(busy),      32'd0);
        check({name, "_symOut"},    32'(symOut),    32'd0);
        serInValid = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        rst = 1'b0;
        tick();
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    initial begin
        int wait_cnt;
        int acc0;

        vecs[0] = '{flag: 1'b0, sym: 4'h5, cnt: 3'd0, exp_n: 1};
        vecs[1] = '{flag: 1'b1, sym: 4'h3, cnt: 3'd0, exp_n: 1};
        vecs[2] = '{flag: 1'b1, sym: 4'hF, cnt: 3'd7, exp_n: 8};
        vecs[3] = '{flag: 1'b1, sym: 4'h0, cnt: 3'd2, exp_n: 3};
        vecs[4] = '{flag: 1'b0, sym: 4'hC, cnt: 3'd5, exp_n: 1};
        vecs[5] = '{flag: 1'b1, sym: 4'h9, cnt: 3'd5, exp_n: 6};

        rst        = 1'b1;
        serIn      = 1'b0;
        serInValid = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        check("por_outValid",  32'(outValid),  32'd0);
        check("por_stackFull", 32'(stackFull), 32'd0);
        check("por_busy",      32'(busy),      32'd0);
        check("por_symOut",    32'(symOut),    32'd0);
        rst = 1'b0;
        tick();

        // Run 1,1010,011: latency and exactly four handshakes
        send_token(1'b1, 4'hA, 3'd3, 0);
        serInValid = 1'b0;
        check("lat_valid_at_k", 32'(outValid), 32'd0);
        check("lat_busy_at_k",  32'(busy),     32'd1);
        tick();
        check("lat_valid_k1", 32'(outValid), 32'd1);
        check("lat_sym_k1",   32'(symOut),   32'hA);
        wait_idle(100);
        push_exp(1'b1, 4'hA, 3'd3);
        compare_queues("run_a");
        check("run_a_busy_after", 32'(busy), 32'd0);

        // Table of single tokens, outReady held high
        for (int v = 0; v < 6; v++) begin
            send_token(vecs[v].flag, vecs[v].sym, vecs[v].cnt, 0);
            serInValid = 1'b0;
            wait_idle(100);
            check($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'(vecs[v].exp_n));
            for (int i = 0; i < got_q.size(); i++)
                check($sformatf("vec%0d_sym%0d", v, i), 32'(got_q[i]), 32'(vecs[v].sym));
            got_q.delete();
            got_t.delete();
        end

        // Literal 0x5 then run 0x3 (count 0): no bubble once both are queued
        rdy_val = 1'b0;
        tick();
        send_token(1'b0, 4'h5, 3'd0, 0);
        send_token(1'b1, 4'h3, 3'd0, 0);
        serInValid = 1'b0;
        repeat (3) tick();
        check("b2b_held_valid", 32'(outValid),  32'd1);
        check("b2b_held_sym",   32'(symOut),    32'h5);
        check("b2b_not_full",   32'(stackFull), 32'd0);
        rdy_val = 1'b1;
        wait_idle(100);
        if (got_t.size() == 2)
            check("b2b_gap_time", 32'(got_t[1] - got_t[0]), 32'd10);
        else
            check("b2b_handshakes", 32'(got_t.size()), 32'd2);
        exp_q.push_back(4'h5);
        exp_q.push_back(4'h3);
        compare_queues("b2b");

        // Backpressure: three runs fill emitter + FIFO, a fourth token stalls
        rdy_val = 1'b0;
        tick();
        acc0        = acc_bits;
        sender_done = 1'b0;
        fork
            begin
                send_token(1'b1, 4'h1, 3'd1, 0);
                send_token(1'b1, 4'h2, 3'd2, 0);
                send_token(1'b1, 4'h7, 3'd0, 0);
                send_token(1'b0, 4'hD, 3'd0, 0);
                serInValid  = 1'b0;
                sender_done = 1'b1;
            end
        join_none
        repeat (40) tick();
        check("bp_stackFull",   32'(stackFull),        32'd1);
        check("bp_bits_taken",  32'(acc_bits - acc0),  32'd24);
        check("bp_outValid",    32'(outValid),         32'd1);
        check("bp_symOut",      32'(symOut),           32'h1);
        check("bp_busy",        32'(busy),             32'd1);
        rdy_mode = 1;
        wait_cnt = 0;
        while (!sender_done && wait_cnt < 2000) begin
            tick();
            wait_cnt++;
        end
        check("bp_sender_done", 32'(sender_done), 32'd1);
        wait_idle(500);
        rdy_mode = 0;
        rdy_val  = 1'b1;
        check("bp_bits_total", 32'(acc_bits - acc0), 32'd29);
        push_exp(1'b1, 4'h1, 3'd1);
        push_exp(1'b1, 4'h2, 3'd2);
        push_exp(1'b1, 4'h7, 3'd0);
        push_exp(1'b0, 4'hD, 3'd0);
        compare_queues("bp");

        // Reset with a full FIFO and a token in the emitter
        rdy_val = 1'b0;
        tick();
        send_token(1'b0, 4'hA, 3'd0, 0);
        send_token(1'b0, 4'hB, 3'd0, 0);
        send_token(1'b0, 4'hC, 3'd0, 0);
        serInValid = 1'b0;
        tick();
        check("rst_full_pre_stackFull", 32'(stackFull), 32'd1);
        do_reset("rst_full");
        rdy_val = 1'b1;
        tick();
        check("rst_full_post_idle", 32'(busy), 32'd0);

        // Reset mid-token: partial bits must be discarded
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        serInValid = 1'b0;
        check("rst_part_pre_busy", 32'(busy), 32'd1);
        #2;
        do_reset("rst_part");
        send_token(1'b0, 4'h6, 3'd0, 0);
        serInValid = 1'b0;
        wait_idle(100);
        exp_q.push_back(4'h6);
        compare_queues("rst_part_fresh");

        // Random source gaps and consumer stalls over 200 tokens
        rdy_mode    = 1;
        sender_done = 1'b0;
        fork
            begin
                logic       f;
                logic [3:0] s;
                logic [2:0] c;
                for (int t = 0; t < 200; t++) begin
                    f = 1'($urandom_range(0, 1));
                    s = 4'($urandom_range(0, 15));
                    c = 3'($urandom_range(0, 7));
                    push_exp(f, s, c);
                    send_token(f, s, c, 2);
                end
                serInValid  = 1'b0;
                sender_done = 1'b1;
            end
        join_none
        wait_cnt = 0;
        while (!sender_done && wait_cnt < 30000) begin
            tick();
            wait_cnt++;
        end
        check("rand_sender_done", 32'(sender_done), 32'd1);
        wait_idle(3000);
        rdy_mode = 0;
        compare_queues("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
